// File: rtl/io_pkg.sv
// Shared definitions for the switch-input debouncer: default filter length
// and the per-channel filter state encoding.
package io_pkg;

  // Board builds override this to roughly 1 ms worth of clock cycles.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer, counter-based debounce filter,
// registered rise/fall pulses and a sticky changed flag.
module debounce_channel
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic clear,
  output logic level,
  output logic rise,
  output logic fall,
  output logic changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             changed_q, changed_d;

  // NOTE: every state flop, including the counter, is asynchronously reset so
  // a pending count can never survive a reset; all updates use <= to keep
  // the synchronizer a true two-stage shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= DB_STABLE;
      cnt_q     <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    changed_d = clear ? 1'b0 : changed_q;

    unique case (state_q)
      DB_STABLE: begin
        if (s2_q != level_q) begin
          state_d = DB_PENDING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      DB_PENDING: begin
        if (s2_q == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Accepted transition; a same-edge clear loses to the new event.
          state_d   = DB_STABLE;
          cnt_d     = '0;
          level_d   = s2_q;
          rise_d    = s2_q;
          fall_d    = ~s2_q;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: rtl/io_input_debouncer.sv
// Conditions raw board switch inputs for the I/O controller: one independent
// synchronizer + debounce filter per channel, all outputs registered.
module io_input_debouncer
  import io_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clear_events,
  output logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .raw    (raw_in[i]),
      .clear  (clear_events),
      .level  (io_in[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i]),
      .changed(changed[i])
    );
  end

endmodule

// File: tb/tb_io_input_debouncer.sv
// Directed self-checking bench for io_input_debouncer with default parameters.
module tb_io_input_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] raw_in;
  logic       clear_events;
  logic [3:0] io_in;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] changed;

  int checks   = 0;
  int failures = 0;

  io_input_debouncer #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .raw_in      (raw_in),
    .clear_events(clear_events),
    .io_in       (io_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .changed     (changed)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_clear();
    clear_events = 1'b1;
    step(1);
    clear_events = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    raw_in = 4'b1111;
    step(3);
    checks++;
    if ({io_in, rise_pulse, fall_pulse, changed} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got io=%b rise=%b fall=%b chg=%b exp all 0",
               io_in, rise_pulse, fall_pulse, changed);
    end
    reset = 1'b0;
    step(17);
    checks++;
    if (io_in !== 4'b0000 || rise_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL reset_early_accept got io=%b rise=%b exp 0000 0000", io_in, rise_pulse);
    end
    step(1);
    checks++;
    if (io_in !== 4'b1111 || rise_pulse !== 4'b1111 || changed !== 4'b1111) begin
      failures++;
      $display("FAIL reset_accept got io=%b rise=%b chg=%b exp 1111 1111 1111",
               io_in, rise_pulse, changed);
    end
    step(1);
    checks++;
    if (rise_pulse !== 4'b0000 || io_in !== 4'b1111) begin
      failures++;
      $display("FAIL reset_pulse_width got rise=%b io=%b exp 0000 1111", rise_pulse, io_in);
    end
    pulse_clear();
    checks++;
    if (changed !== 4'b0000) begin
      failures++;
      $display("FAIL reset_clear got chg=%b exp 0000", changed);
    end
  endtask

  task automatic test_fall();
    raw_in = 4'b1101;
    step(17);
    checks++;
    if (io_in !== 4'b1111 || fall_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL fall_early got io=%b fall=%b exp 1111 0000", io_in, fall_pulse);
    end
    step(1);
    checks++;
    if (io_in !== 4'b1101 || fall_pulse !== 4'b0010 || rise_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL fall_accept got io=%b fall=%b rise=%b exp 1101 0010 0000",
               io_in, fall_pulse, rise_pulse);
    end
    step(1);
    checks++;
    if (fall_pulse !== 4'b0000 || rise_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL fall_pulse_width got fall=%b rise=%b exp 0000 0000", fall_pulse, rise_pulse);
    end
    raw_in = 4'b0000;
    step(20);
    pulse_clear();
    checks++;
    if (io_in !== 4'b0000 || changed !== 4'b0000) begin
      failures++;
      $display("FAIL fall_restore got io=%b chg=%b exp 0000 0000", io_in, changed);
    end
  endtask

  task automatic test_glitch();
    raw_in = 4'b0001;
    step(15);
    raw_in = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++;
      if (io_in[0] !== 1'b0 || rise_pulse !== 4'b0000) begin
        failures++;
        $display("FAIL glitch15_cycle%0d got io0=%b rise=%b exp 0 0000", k, io_in[0], rise_pulse);
      end
    end
    checks++;
    if (changed[0] !== 1'b0) begin
      failures++;
      $display("FAIL glitch15_changed got %b exp 0", changed[0]);
    end
    raw_in = 4'b0001;
    step(16);
    raw_in = 4'b0000;
    step(1);
    checks++;
    if (io_in[0] !== 1'b0) begin
      failures++;
      $display("FAIL glitch16_early got io0=%b exp 0", io_in[0]);
    end
    step(1);
    checks++;
    if (io_in[0] !== 1'b1 || rise_pulse !== 4'b0001 || changed[0] !== 1'b1) begin
      failures++;
      $display("FAIL glitch16_accept got io0=%b rise=%b chg0=%b exp 1 0001 1",
               io_in[0], rise_pulse, changed[0]);
    end
    step(1);
    checks++;
    if (rise_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL glitch16_pulse_width got rise=%b exp 0000", rise_pulse);
    end
    step(20);
    pulse_clear();
    checks++;
    if (io_in !== 4'b0000 || changed !== 4'b0000) begin
      failures++;
      $display("FAIL glitch_restore got io=%b chg=%b exp 0000 0000", io_in, changed);
    end
  endtask

  task automatic test_bounce();
    int extra;
    for (int k = 0; k < 10; k++) begin
      raw_in[2] = (k % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        checks++;
        if (rise_pulse !== 4'b0000 || io_in !== 4'b0000) begin
          failures++;
          $display("FAIL bounce_seg%0d got rise=%b io=%b exp 0000 0000", k, rise_pulse, io_in);
        end
      end
    end
    raw_in[2] = 1'b1;
    step(17);
    checks++;
    if (io_in[2] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_early got io2=%b exp 0", io_in[2]);
    end
    step(1);
    checks++;
    if (rise_pulse !== 4'b0100 || io_in !== 4'b0100) begin
      failures++;
      $display("FAIL bounce_accept got rise=%b io=%b exp 0100 0100", rise_pulse, io_in);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (rise_pulse !== 4'b0000) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL bounce_extra_pulses got %0d exp 0", extra);
    end
  endtask

  task automatic test_clear_collision();
    raw_in = 4'b1100;
    step(17);
    clear_events = 1'b1;
    step(1);
    clear_events = 1'b0;
    checks++;
    if (io_in !== 4'b1100 || rise_pulse !== 4'b1000 || changed !== 4'b1000) begin
      failures++;
      $display("FAIL collision got io=%b rise=%b chg=%b exp 1100 1000 1000",
               io_in, rise_pulse, changed);
    end
    pulse_clear();
    checks++;
    if (changed !== 4'b0000) begin
      failures++;
      $display("FAIL collision_reclear got chg=%b exp 0000", changed);
    end
  endtask

  task automatic test_reset_mid();
    raw_in = 4'b1101;
    step(12);
    reset = 1'b1;
    #1;
    checks++;
    if ({io_in, rise_pulse, fall_pulse, changed} !== 16'h0) begin
      failures++;
      $display("FAIL midreset_outputs got io=%b rise=%b fall=%b chg=%b exp all 0",
               io_in, rise_pulse, fall_pulse, changed);
    end
    step(2);
    reset = 1'b0;
    step(17);
    checks++;
    if (io_in !== 4'b0000 || rise_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_early got io=%b rise=%b exp 0000 0000", io_in, rise_pulse);
    end
    step(1);
    checks++;
    if (io_in !== 4'b1101 || rise_pulse !== 4'b1101 || changed !== 4'b1101) begin
      failures++;
      $display("FAIL midreset_accept got io=%b rise=%b chg=%b exp 1101 1101 1101",
               io_in, rise_pulse, changed);
    end
    step(1);
    checks++;
    if (rise_pulse !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_pulse_width got rise=%b exp 0000", rise_pulse);
    end
  endtask

  initial begin
    reset        = 1'b1;
    raw_in       = 4'b0000;
    clear_events = 1'b0;
    test_reset();
    test_fall();
    test_glitch();
    test_bounce();
    test_clear_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
